code_decoder_stream: RTL and testbench
======================================

# code_decoder_stream

Registered, flow-controlled 3-to-8 decoder: the inverse of the 8-to-3 priority encoder in the signal/binary conversion tasks. Accepts 3-bit codes over a valid/ready handshake and emits 8-bit one-hot or thermometer words in order. Input and output are decoupled by a small FIFO. Feeding any output word back into the priority encoder returns the original code, which is the round-trip property the bench relies on.

## Interface
- DEPTH, 2, FIFO entries behind the output register; at least 1. Total buffering is DEPTH+1 words.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers {in_mode, in_code}.
- in_ready  out  1  block can take a word this cycle.
- in_code  in  3  binary code, 0..7.
- in_mode  in  1  0 = one-hot, 1 = thermometer.
- out_valid  out  1  out_bits holds a decoded word.
- out_ready  in  1  consumer takes the word this cycle.
- out_bits  out  8  decoded word.
- out_count  out  16  number of completed output handshakes since reset; wraps.

## Operation
- Decode rules:
  - One-hot: out_bits = 1 << code.
  - Thermometer: out_bits[i] = 1 for every i ≤ code.
  - Code 0 gives 8'h01 in both modes.
  - Code 7 gives 8'h80 (one-hot) or 8'hFF (thermometer).
- Input handshake: a word is accepted on a rising edge where in_valid && in_ready.
- Output handshake: a word is consumed on a rising edge where out_valid && out_ready.
- Storage:
  - The output register holds the decoded word.
  - The FIFO holds raw {mode, code} entries, 4 bits each.
  - Decoding happens when a word is loaded into the output register.
- Output register update. It loads when it is empty or being consumed (!out_valid || out_ready), with this priority:
  - FIFO non-empty: load the decoded FIFO head and pop it.
  - Else, if an input is accepted this cycle: load the decoded input directly (bypass). The word is not written to the FIFO.
  - Else: out_valid clears to 0.
- Any accepted input that does not bypass is pushed to the FIFO.
- Order is strictly preserved.
- in_ready = (fifo_count < DEPTH). It depends only on registered state, so there is no combinational path from out_ready to in_ready.
- Full FIFO with a pop on the same edge: in_ready is already low, so no push. in_ready rises on the following cycle.
- out_bits keeps its value while out_valid = 0. Consumers ignore it.
- out_count increments by 1 per output handshake and wraps 16'hFFFF -> 0.
- No illegal inputs exist; all 8 codes are valid in both modes.

## Timing
- Reset values:
  - out_valid = 0, out_bits = 8'h00, out_count = 0.
  - FIFO empty, so in_ready = 1 in the cycle after reset deasserts.
  - in_ready = 1 while rst is held.
- Reset mid-operation: all buffered words are discarded and none are emitted afterwards. Handshakes on the same edge as rst are ignored.
- Latency: 1 cycle. A word accepted at edge N, with an empty FIFO and the output register free, is valid in the cycle following edge N.
- Throughput: 1 word/cycle sustained with out_ready = 1.
- Backpressure with out_ready = 0: exactly DEPTH+1 words are accepted, then in_ready = 0.
- The output holds stable while out_valid && !out_ready.

## Structure
- Package `code_decoder_pkg`:
  - CODE_W = 3, OUT_W = 8.
  - `typedef enum logic {ONEHOT, THERMO} dec_mode_t`.
  - `function decode(mode, code)`, shared with the bench model.
- Sub-module `sync_fifo`: parameterised width and depth; push/pop/full/empty/count. Same clk/rst.
- Top level: output-register control, bypass mux, out_count.

## Test plan
- Reset: rst held 3 cycles -> out_valid = 0, out_bits = 8'h00, out_count = 0. in_ready = 1 after release.
- One-hot: code 5, mode 0 accepted at edge N, out_ready = 1 -> out_bits = 8'h20, out_valid high for exactly the next cycle, out_count = 1.
- Thermometer sweep: codes 0..7, mode 1, back-to-back, out_ready = 1 -> 8'h01, 03, 07, 0F, 1F, 3F, 7F, FF on consecutive cycles. Each word fed to the priority encoder returns its code.
- Backpressure (DEPTH = 2): out_ready = 0, push codes 1, 2, 3, 4 in one-hot mode -> first three accepted, in_ready = 0 from the third acceptance on. Then out_ready = 1 -> 8'h02, 04, 08, after which code 4 is accepted. No loss, no reorder.
- Random stalls: random in_valid/out_ready over 10k words -> output matches the scoreboard, out_count equals the handshake count mod 2^16.
- Reset mid-stream: rst asserted with 3 words buffered -> next cycle out_valid = 0, out_count = 0, and no stale word appears afterwards.

Source files
------------

// File: rtl/code_decoder_pkg.sv
// Shared types and the code-to-word decode rule for the registered 3-to-8 decoder.
// The decode function is the single definition of one-hot / thermometer output.
package code_decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic {
        ONEHOT = 1'b0,
        THERMO = 1'b1
    } dec_mode_t;

    // One-hot sets only bit `code`; thermometer sets every bit at or below `code`.
    function automatic logic [OUT_W-1:0] decode(input dec_mode_t mode,
                                                input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] word;
        word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (mode == THERMO) begin
                word[i] = (i <= int'(code));
            end else begin
                word[i] = (i == int'(code));
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; pushing when full or popping when
// empty is never requested by the owner, so neither case is guarded here.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/code_decoder_stream.sv
// Flow-controlled 3-to-8 decoder: raw {mode, code} entries queue in a FIFO and
// are decoded as they load into the output register; an idle path bypasses the FIFO.
module code_decoder_stream
    import code_decoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_bits,
    output logic [15:0]       out_count
);

    localparam int ENTRY_W = CODE_W + 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic in_fire;
    logic out_fire;
    logic load;
    logic fifo_pop;
    logic bypass;
    logic fifo_push;

    // Handshakes: a word moves on a rising edge where valid && ready are both high;
    // in_ready comes from registered FIFO occupancy only, never from out_ready.
    assign in_ready  = rst || (int'(fifo_count) < DEPTH);
    assign in_fire   = in_valid && in_ready && !rst;
    assign out_fire  = out_valid && out_ready;

    // Output register refills when empty or draining; the FIFO head has priority
    // over a fresh input so order is preserved.
    assign load      = !out_valid || out_ready;
    assign fifo_pop  = load && !fifo_empty;
    assign bypass    = load && fifo_empty && in_fire;
    assign fifo_push = in_fire && !bypass;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_mode, in_code}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_count <= '0;
        end else begin
            if (out_fire) begin
                out_count <= out_count + 16'd1;
            end
            if (load) begin
                if (!fifo_empty) begin
                    out_valid <= 1'b1;
                    out_bits  <= decode(dec_mode_t'(fifo_head[CODE_W]),
                                        fifo_head[CODE_W-1:0]);
                end else if (in_fire) begin
                    out_valid <= 1'b1;
                    out_bits  <= decode(dec_mode_t'(in_mode), in_code);
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // The full flag and the occupancy count must always agree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (int'(fifo_count) == DEPTH))
                else $error("fifo full flag disagrees with count");
        end
    end

endmodule

// File: tb/tb_code_decoder_stream.sv
// Directed and random-stall bench for code_decoder_stream with DEPTH = 2;
// each scenario task drives its own stimulus and checks results inline.
module tb_code_decoder_stream;

    localparam int DEPTH    = 2;
    localparam int N_RANDOM = 10000;
    localparam int BUDGET   = 60000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_code;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bits;
    logic [15:0] out_count;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_count;
    logic [7:0]  exp_q[$];

    code_decoder_stream #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_count (out_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference: one-hot is a shift, thermometer is 2^(code+1)-1.
    function automatic logic [7:0] model(input logic mode, input logic [2:0] code);
        logic [8:0] t;
        if (mode) begin
            t = (9'd2 << code) - 9'd1;
            return t[7:0];
        end
        return 8'h01 << code;
    endfunction

    function automatic int prio_enc(input logic [7:0] w);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) idx = i;
        end
        return idx;
    endfunction

    // driver: advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_code = 3'd0;
        in_mode = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_bits !== 8'h00) begin n_fail++; $display("FAIL reset_out_bits got %h want 00", out_bits); end
        n_checks++;
        if (out_count !== 16'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_held got %b want 1", in_ready); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
        exp_count = 16'd0;
    endtask

    task automatic test_onehot();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_code = 3'd5;
        in_mode = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL onehot_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_bits !== 8'h20) begin n_fail++; $display("FAIL onehot_bits got %h want 20", out_bits); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL onehot_valid_drop got %b want 0", out_valid); end
        exp_count = exp_count + 16'd1;
        n_checks++;
        if (out_count !== exp_count) begin n_fail++; $display("FAIL onehot_count got %0d want %0d", out_count, exp_count); end
    endtask

    task automatic test_thermo_sweep();
        logic [7:0] thermo_tab [8];
        thermo_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        out_ready = 1'b1;
        in_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_code = 3'(i);
            tick();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid code %0d got %b want 1", i, out_valid); end
            n_checks++;
            if (out_bits !== thermo_tab[i]) begin n_fail++; $display("FAIL sweep_bits code %0d got %h want %h", i, out_bits, thermo_tab[i]); end
            n_checks++;
            if (prio_enc(out_bits) != i) begin n_fail++; $display("FAIL sweep_roundtrip code %0d got %0d want %0d", i, prio_enc(out_bits), i); end
        end
        in_valid = 1'b0;
        tick();
        exp_count = exp_count + 16'd8;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_idle got %b want 0", out_valid); end
        n_checks++;
        if (out_count !== exp_count) begin n_fail++; $display("FAIL sweep_count got %0d want %0d", out_count, exp_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_mode = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            in_valid = 1'b1;
            in_code = 3'(c);
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept code %0d in_ready got %b want 1", c, in_ready); end
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full in_ready got %b want 0", in_ready); end
        in_code = 3'd4;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold in_ready got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b1 || out_bits !== 8'h02) begin n_fail++; $display("FAIL bp_stable got v=%b %h want v=1 02", out_valid, out_bits); end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_bits !== 8'h04) begin n_fail++; $display("FAIL bp_word2 got %h want 04", out_bits); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_bits !== 8'h08) begin n_fail++; $display("FAIL bp_word3 got %h want 08", out_bits); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_bits !== 8'h10) begin n_fail++; $display("FAIL bp_word4 got v=%b %h want v=1 10", out_valid, out_bits); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", out_valid); end
        exp_count = exp_count + 16'd4;
        n_checks++;
        if (out_count !== exp_count) begin n_fail++; $display("FAIL bp_count got %0d want %0d", out_count, exp_count); end
    endtask

    task automatic test_random_stalls();
        int         sent;
        int         recv;
        int         cycles;
        logic       took_in;
        logic       took_out;
        logic       held;
        logic [7:0] held_bits;
        logic [7:0] e;
        sent = 0;
        recv = 0;
        cycles = 0;
        took_in = 1'b0;
        held = 1'b0;
        held_bits = 8'h00;
        in_valid = 1'b0;
        exp_q.delete();
        while (recv < N_RANDOM && cycles < BUDGET) begin
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_bits !== held_bits) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold got v=%b %h want v=1 %h", out_valid, out_bits, held_bits);
                end
            end
            if (sent < N_RANDOM) begin
                if (!in_valid || took_in) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_code = 3'($urandom_range(0, 7));
                    in_mode = 1'($urandom_range(0, 1));
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            took_in = in_valid && in_ready;
            took_out = out_valid && out_ready;
            if (took_in) begin
                exp_q.push_back(model(in_mode, in_code));
                sent++;
            end
            if (took_out) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected_word got %h want none", out_bits);
                end else begin
                    e = exp_q.pop_front();
                    if (out_bits !== e) begin
                        n_fail++;
                        $display("FAIL rand_word %0d got %h want %h", recv, out_bits, e);
                    end
                end
                recv++;
            end
            held = out_valid && !out_ready;
            held_bits = out_bits;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv != N_RANDOM) begin n_fail++; $display("FAIL rand_timeout got %0d words want %0d", recv, N_RANDOM); end
        exp_count = exp_count + 16'(recv);
        n_checks++;
        if (out_count !== exp_count) begin n_fail++; $display("FAIL rand_count got %0d want %0d", out_count, exp_count); end
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain got pending=%0d v=%b want 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        in_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_code = 3'(6 - 3 * c);
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_buffered in_ready got %b want 0", in_ready); end
        rst = 1'b1;
        in_code = 3'd7;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", out_count); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cycle %0d got %b want 0", k, out_valid); end
        end
        in_valid = 1'b1;
        in_code = 3'd2;
        in_mode = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_bits !== 8'h04) begin n_fail++; $display("FAIL mid_restart got v=%b %h want v=1 04", out_valid, out_bits); end
        tick();
        n_checks++;
        if (out_count !== 16'd1) begin n_fail++; $display("FAIL mid_restart_count got %0d want 1", out_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_count = 16'd0;
        test_reset();
        test_onehot();
        test_thermo_sweep();
        test_backpressure();
        test_random_stalls();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
